// File: rtl/inv_key_expansion.sv
// inv_key_expansion
//   Reverse-order AES-128 round-key generator for the decryption datapath.
//   Takes the round-10 key and walks the key schedule backwards, handing out
//   round keys 10, 9, ..., 0 over a valid/ready handshake.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   start_i      load request, sampled only while idle
//   last_key_i   round-10 key, captured on an accepted start
//   round_key_o  current round key (registered)
//   round_o      round index of round_key_o (10 down to 0)
//   key_valid_o  round_key_o/round_o valid
//   key_ready_i  consumer accepts the key while key_valid_o=1
//   busy_o       high from the cycle after a start until round 0 is accepted
//   done_o       one-cycle pulse after the round-0 key is accepted
//
// Word j of a key sits in bits [32j+31:32j]; the first FIPS-197 byte of a
// word is in its bits [31:24].
module inv_key_expansion #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [127:0] last_key_i,
  output logic [127:0] round_key_o,
  output logic [3:0]   round_o,
  output logic         key_valid_o,
  input  logic         key_ready_i,
  output logic         busy_o,
  output logic         done_o
);

  typedef enum logic [1:0] {IDLE, EMIT, CALC} state_t;

  // Forward AES S-box; index 0 is the leftmost byte of the literal.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  state_t       state, state_n;
  logic [127:0] key_n;
  logic [3:0]   round_n;
  logic         done_n;

  logic [31:0]  p0, p1, p2, p3;
  logic [31:0]  rot_p3, sub_p3;
  logic [7:0]   rcon;
  logic [127:0] prev_key;

  // Rcon for the round currently held; the step from round r uses Rcon[r].
  always_comb begin
    rcon = 8'h00;
    case (round_o)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // One backward schedule step. p3 must be formed before p0, since p0's
  // SubWord/RotWord term is taken from the previous round's last word.
  always_comb begin
    p3       = round_key_o[127:96] ^ round_key_o[95:64];
    p2       = round_key_o[95:64]  ^ round_key_o[63:32];
    p1       = round_key_o[63:32]  ^ round_key_o[31:0];
    rot_p3   = {p3[23:0], p3[31:24]};
    sub_p3   = {sbox(rot_p3[31:24]), sbox(rot_p3[23:16]),
                sbox(rot_p3[15:8]),  sbox(rot_p3[7:0])};
    p0       = round_key_o[31:0] ^ sub_p3 ^ {rcon, 24'h000000};
    prev_key = {p3, p2, p1, p0};
  end

  // Next-state and output decode.
  always_comb begin
    state_n     = state;
    key_n       = round_key_o;
    round_n     = round_o;
    done_n      = 1'b0;
    key_valid_o = (state == EMIT);
    busy_o      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start_i) begin
          key_n   = last_key_i;
          round_n = 4'(NUM_ROUNDS);
          state_n = EMIT;
        end
      end
      EMIT: begin
        if (key_ready_i) begin
          if (round_o == 4'd0) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = CALC;
          end
        end
      end
      CALC: begin
        key_n   = prev_key;
        round_n = round_o - 4'd1;
        state_n = EMIT;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      round_key_o <= '0;
      round_o     <= '0;
      done_o      <= 1'b0;
    end else begin
      state       <= state_n;
      round_key_o <= key_n;
      round_o     <= round_n;
      done_o      <= done_n;
    end
  end

endmodule

// File: tb/tb_inv_key_expansion.sv
module tb_inv_key_expansion;

  logic         clk;
  logic         rst;
  logic         start_i;
  logic [127:0] last_key_i;
  logic [127:0] round_key_o;
  logic [3:0]   round_o;
  logic         key_valid_o;
  logic         key_ready_i;
  logic         busy_o;
  logic         done_o;

  inv_key_expansion #(.NUM_ROUNDS(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .last_key_i  (last_key_i),
    .round_key_o (round_key_o),
    .round_o     (round_o),
    .key_valid_o (key_valid_o),
    .key_ready_i (key_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   rnd;
    logic [127:0] key;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [127:0] FIPS_LAST = 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8;
  localparam logic [127:0] FIPS_R1   = 128'h2a6c7605_23a33939_88542cb1_a0fafe17;
  localparam logic [127:0] FIPS_R0   = 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516;
  localparam logic [127:0] ZERO_LAST = 128'h6f8f188e_23e951cf_3e92e211_b4ef5bcb;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: GF(2^8) arithmetic + FIPS word schedule
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] b);
    if (b == 8'h00) return 8'h00;
    for (int x = 1; x < 256; x++)
      if (gmul(b, 8'(x)) == 8'h01) return 8'(x);
    return 8'h00;
  endfunction

  function automatic logic [7:0] aes_sbox(input logic [7:0] b);
    logic [7:0] i;
    i = ginv(b);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon_of(input int r);
    logic [7:0] rc;
    rc = 8'h01;
    for (int k = 1; k < r; k++) rc = xtime(rc);
    return rc;
  endfunction

  // Rebuild the whole 44-word schedule backwards from w[40..43] and queue
  // round keys in the order the consumer will see them.
  task automatic push_expected(input logic [127:0] last);
    logic [31:0] w [44];
    logic [31:0] t;
    exp_t e;
    for (int j = 0; j < 4; j++) w[40 + j] = last[32*j +: 32];
    for (int i = 43; i >= 4; i--) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {aes_sbox(t[31:24]), aes_sbox(t[23:16]), aes_sbox(t[15:8]), aes_sbox(t[7:0])};
        t = t ^ {rcon_of(i / 4), 24'h000000};
      end
      w[i - 4] = w[i] ^ t;
    end
    for (int r = 10; r >= 0; r--) begin
      e.rnd = 4'(r);
      e.key = {w[4*r + 3], w[4*r + 2], w[4*r + 1], w[4*r]};
      q.push_back(e);
    end
  endtask

  // ---------------- monitor / scoreboard
  logic calc_flag = 1'b0;
  logic done_exp  = 1'b0;

  always @(negedge clk) begin
    logic exp_valid;
    exp_t e;
    if (rst) begin
      chk("rst_key",   round_key_o,       '0);
      chk("rst_round", 128'(round_o),     '0);
      chk("rst_valid", 128'(key_valid_o), '0);
      chk("rst_busy",  128'(busy_o),      '0);
      chk("rst_done",  128'(done_o),      '0);
      calc_flag = 1'b0;
      done_exp  = 1'b0;
    end else begin
      exp_valid = (q.size() > 0) && !calc_flag;
      chk("valid", 128'(key_valid_o), 128'(exp_valid));
      chk("busy",  128'(busy_o),      128'(q.size() > 0));
      chk("done",  128'(done_o),      128'(done_exp));
      calc_flag = 1'b0;
      done_exp  = 1'b0;
      if (exp_valid && key_valid_o) begin
        chk("round", 128'(round_o), 128'(q[0].rnd));
        chk("key",   round_key_o,   q[0].key);
        if (key_ready_i) begin
          e = q.pop_front();
          if (e.rnd == 4'd0) done_exp = 1'b1;
          else               calc_flag = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge+#1, DUT idle)
  task automatic start_seq(input logic [127:0] key);
    start_i    = 1'b1;
    last_key_i = key;
    @(posedge clk);
    push_expected(key);
    #1;
    start_i = 1'b0;
  endtask

  // Returns in the done cycle (posedge+#1) once every queued key was consumed.
  task automatic run_until_idle(input bit rand_ready, input bit spam);
    bit finished;
    finished = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (q.size() == 0) begin
        finished = 1'b1;
        break;
      end
      key_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (spam && q.size() > 1) begin
        start_i    = 1'b1;
        last_key_i = {$urandom(), $urandom(), $urandom(), $urandom()};
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    start_i = 1'b0;
    n_checks++;
    if (!finished) begin
      n_fail++;
      $display("FAIL seq_timeout: got %0d keys outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

  initial begin
    bit found;
    rst         = 1'b1;
    start_i     = 1'b0;
    last_key_i  = '0;
    key_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // FIPS-197 vector, ready high, with fixed cycle positions.
    key_ready_i = 1'b1;
    start_seq(FIPS_LAST);                              // cycle 1
    chk("c1_valid", 128'(key_valid_o), 128'd1);
    chk("c1_round", 128'(round_o), 128'd10);
    repeat (18) begin @(posedge clk); #1; end          // cycle 19
    chk("c19_round", 128'(round_o), 128'd1);
    chk("c19_key",   round_key_o,   FIPS_R1);
    repeat (2) begin @(posedge clk); #1; end           // cycle 21
    chk("c21_valid", 128'(key_valid_o), 128'd1);
    chk("c21_round", 128'(round_o), 128'd0);
    chk("c21_key",   round_key_o,   FIPS_R0);
    @(posedge clk); #1;                                // cycle 22
    chk("c22_done", 128'(done_o), 128'd1);
    chk("c22_busy", 128'(busy_o), 128'd0);

    // Start during the done pulse, with the zero-key vector.
    start_seq(ZERO_LAST);                              // cycle 23
    chk("c23_done",  128'(done_o), 128'd0);
    chk("c23_valid", 128'(key_valid_o), 128'd1);
    chk("c23_round", 128'(round_o), 128'd10);
    run_until_idle(1'b0, 1'b0);
    chk("zero_r0_key", round_key_o, '0);
    repeat (3) begin @(posedge clk); #1; end
    chk("hold_key",   round_key_o,   '0);
    chk("hold_round", 128'(round_o), '0);

    // Backpressure over the FIPS vector.
    start_seq(FIPS_LAST);
    run_until_idle(1'b1, 1'b0);
    chk("bp_r0_key", round_key_o, FIPS_R0);

    // Starts with other keys while busy must be ignored.
    start_seq(FIPS_LAST);
    run_until_idle(1'b0, 1'b1);
    start_seq({$urandom(), $urandom(), $urandom(), $urandom()});
    run_until_idle(1'b1, 1'b1);

    // Reset in the middle of a sequence.
    start_seq({$urandom(), $urandom(), $urandom(), $urandom()});
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      key_ready_i = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      if (round_o == 4'd5) begin
        found = 1'b1;
        break;
      end
    end
    chk("reached_r5", 128'(found), 128'd1);
    rst = 1'b1;
    q.delete();
    #1;
    chk("mid_rst_key",   round_key_o,       '0);
    chk("mid_rst_round", 128'(round_o),     '0);
    chk("mid_rst_valid", 128'(key_valid_o), '0);
    chk("mid_rst_busy",  128'(busy_o),      '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    start_seq(FIPS_LAST);
    run_until_idle(1'b1, 1'b0);
    chk("post_rst_r0_key", round_key_o, FIPS_R0);

    // A few random keys under random backpressure.
    for (int n = 0; n < 6; n++) begin
      start_seq({$urandom(), $urandom(), $urandom(), $urandom()});
      run_until_idle(1'b1, 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
